// File: rtl/fp16_pkg.sv
// fp16_pkg: shared constants, FSM state type and FP16 field helpers for the
// FP16 processing unit and its mantissa multiplier.
package fp16_pkg;

    localparam int unsigned MANT_W = 11;            // significand incl. hidden bit
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned BIAS   = 15;
    localparam int unsigned PROD_W = 2 * MANT_W;    // full significand product
    localparam int unsigned CNT_W  = $clog2(MANT_W + 1);

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StMult,
        StNorm,
        StDone
    } state_t;

    function automatic logic fp_sign(input logic [15:0] x);
        return x[15];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [15:0] x);
        return x[14:10];
    endfunction

    function automatic logic [MANT_W-2:0] fp_frac(input logic [15:0] x);
        return x[9:0];
    endfunction

endpackage

// File: rtl/fp16_mant_mul.sv
// fp16_mant_mul: sequential MANT_W x MANT_W shift-add multiplier, one
// multiplier bit per cycle.
//   clk, reset : clock and synchronous active-high reset
//   load       : start a new multiply with mcand/mplier
//   mcand      : multiplicand
//   mplier     : multiplier
//   busy       : iterations in progress
//   prod       : product, valid from the cycle after done
//   done       : high during the final iteration
module fp16_mant_mul
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [MANT_W-1:0] mcand,
    input  logic [MANT_W-1:0] mplier,
    output logic              busy,
    output logic [PROD_W-1:0] prod,
    output logic              done
);

    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] mc_q;
    logic [MANT_W-1:0] mp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            mc_q   <= '0;
            mp_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (load) begin
            acc_q  <= '0;
            mc_q   <= PROD_W'(mcand);
            mp_q   <= mplier;
            cnt_q  <= CNT_W'(MANT_W);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (mp_q[0]) begin
                acc_q <= acc_q + mc_q;
            end
            mc_q  <= mc_q << 1;
            mp_q  <= mp_q >> 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign prod = acc_q;
    assign done = busy_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fp16_processing_unit.sv
// fp16_processing_unit: multi-cycle FP16 multiplier, P = a * b with
// round-to-nearest-even. Subnormal inputs read as zero, subnormal results
// flush to zero.
//   clk, reset : clock and synchronous active-high reset
//   start      : level request, sampled only while idle
//   a, b       : FP16 operands, captured when start is accepted
//   P          : registered product, holds until the next completion
//   ready      : one-cycle pulse, P valid in the same cycle
module fp16_processing_unit
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] P,
    output logic        ready
);

    state_t state_q, state_d;

    logic [15:0]       a_q, b_q;
    logic              sign_q;
    logic signed [6:0] exp_q;
    logic              special_q;
    logic [15:0]       special_val_q;
    logic [15:0]       p_q;

    logic              mul_load, mul_busy, mul_done;
    logic [PROD_W-1:0] mul_prod;

    // Operand classification
    logic [EXP_W-1:0] ea, eb;
    logic [9:0]       fa, fb;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_r;
    logic             special_c;
    logic [15:0]      special_val_c;

    always_comb begin
        ea     = fp_exp(a_q);
        eb     = fp_exp(b_q);
        fa     = fp_frac(a_q);
        fb     = fp_frac(b_q);
        sign_r = fp_sign(a_q) ^ fp_sign(b_q);
        zero_a = (ea == '0);
        zero_b = (eb == '0);
        inf_a  = (ea == '1) && (fa == '0);
        inf_b  = (eb == '1) && (fb == '0);
        nan_a  = (ea == '1) && (fa != '0);
        nan_b  = (eb == '1) && (fb != '0);
        special_c     = 1'b1;
        special_val_c = QNAN;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            special_val_c = QNAN;
        end else if (inf_a || inf_b) begin
            special_val_c = {sign_r, POS_INF[14:0]};
        end else if (zero_a || zero_b) begin
            special_val_c = {sign_r, 15'h0};
        end else begin
            special_c = 1'b0;
        end
    end

    // Normalise and round
    logic              hi, guard, sticky, round_up;
    logic [9:0]        frac_t;
    logic [11:0]       mant_r;
    logic signed [6:0] exp_n;
    logic [15:0]       result;

    always_comb begin
        hi = mul_prod[PROD_W-1];
        if (hi) begin
            frac_t = mul_prod[20:11];
            guard  = mul_prod[10];
            sticky = |mul_prod[9:0];
        end else begin
            frac_t = mul_prod[19:10];
            guard  = mul_prod[9];
            sticky = |mul_prod[8:0];
        end
        round_up = guard && (sticky || frac_t[0]);
        mant_r   = {2'b01, frac_t} + 12'(round_up);
        // On rounding carry-out mant_r is 12'h800, so its low fraction bits are already zero.
        exp_n    = exp_q + 7'(hi) + 7'(mant_r[11]);
        if (special_q) begin
            result = special_val_q;
        end else if (exp_n >= 7'sd31) begin
            result = {sign_q, POS_INF[14:0]};
        end else if (exp_n <= 7'sd0) begin
            result = {sign_q, 15'h0};
        end else begin
            result = {sign_q, exp_n[4:0], mant_r[9:0]};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StUnpack;
            StUnpack: state_d = StMult;
            StMult:   if (mul_done) state_d = StNorm;
            StNorm:   state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        mul_load = (state_q == StUnpack) && !mul_busy;
        ready    = (state_q == StDone);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q           <= '0;
            b_q           <= '0;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            p_q           <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == StUnpack) begin
                sign_q        <= sign_r;
                exp_q         <= 7'({2'b00, ea}) + 7'({2'b00, eb}) - 7'(BIAS);
                special_q     <= special_c;
                special_val_q <= special_val_c;
            end
            if (state_q == StNorm) begin
                p_q <= result;
            end
        end
    end

    assign P = p_q;

    fp16_mant_mul u_mant_mul (
        .clk    (clk),
        .reset  (reset),
        .load   (mul_load),
        .mcand  ({~zero_a, fa}),
        .mplier ({~zero_b, fb}),
        .busy   (mul_busy),
        .prod   (mul_prod),
        .done   (mul_done)
    );

endmodule

// File: tb/tb_fp16_processing_unit.sv
// Directed testbench for fp16_processing_unit with hand-computed products.
module tb_fp16_processing_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic [15:0] P;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp16_processing_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .P     (P),
        .ready (ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts negedges until ready is seen, bounded at 40.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
    endtask

    // Watches for any ready pulse over a number of cycles.
    task automatic watch_no_ready(input int cycles, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | ready;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp_p);
        int n;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_ready(n);
        check({tag, " latency"}, n, 14);
        check({tag, " P"}, P, exp_p);
        @(negedge clk);
        check({tag, " pulse"}, ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   n, n2;
        logic seen;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset P", P, 16'h0000);
        check("reset ready", ready, 0);
        reset = 1'b0;
        watch_no_ready(20, seen);
        check("idle no ready", seen, 0);

        run_op("4x6", 16'h4400, 16'h4600, 16'h4E00);

        // Back-to-back with operand change mid-op
        @(negedge clk);
        a     = 16'h4400;
        b     = 16'h4600;
        start = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) @(negedge clk);
        a = 16'h4000;
        b = 16'hC400;
        wait_ready(n);
        check("b2b first latency", n + 4, 14);
        check("b2b first P", P, 16'h4E00);
        wait_ready(n2);
        start = 1'b0;
        check("b2b second interval", n2, 15);
        check("b2b second P", P, 16'hC800);
        @(negedge clk);
        check("b2b pulse", ready, 0);

        run_op("inf*0", 16'h7C00, 16'h0000, 16'h7E00);
        run_op("max*max", 16'h7BFF, 16'h7BFF, 16'h7C00);
        run_op("underflow", 16'h0400, 16'h0400, 16'h0000);
        run_op("-0*1", 16'h8000, 16'h3C00, 16'h8000);
        run_op("nan*1", 16'h7C01, 16'h3C00, 16'h7E00);
        run_op("-inf*2", 16'hFC00, 16'h4000, 16'hFC00);
        run_op("round", 16'h3C01, 16'h3C01, 16'h3C02);
        run_op("1.5*1.5", 16'h3E00, 16'h3E00, 16'h4080);

        // Reset during MULT aborts the op
        @(negedge clk);
        a     = 16'h4400;
        b     = 16'h4600;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        watch_no_ready(20, seen);
        check("abort no ready", seen, 0);
        check("abort P", P, 16'h0000);
        run_op("after abort", 16'h4000, 16'hC400, 16'hC800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
